// File: rtl/trace_drain.sv
// Trace record drain: record FIFO plus word serialiser on a valid/ready stream.
// Optional timestamp header word per frame: define TRACE_DRAIN_TIMESTAMP_EN.
module trace_drain #(
  parameter int RECORD_WIDTH = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RECORD_WIDTH-1:0]       trace_data_i,
  input  logic                          trace_ready_i,
  input  logic                          trace_capture_enable_i,
  input  logic                          lock_i,
  input  logic [31:0]                   counter_i,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic                          drained
);

  localparam int WORDS = RECORD_WIDTH / WORD_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

`ifdef TRACE_DRAIN_TIMESTAMP_EN
  typedef enum logic [1:0] {IDLE, HDR, SEND} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif

  state_e                  state_q;
  logic [AW:0]             wr_q, rd_q, wr_d, rd_d;
  logic [RECORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [RECORD_WIDTH-1:0] head;
  logic [RECORD_WIDTH-1:0] shift_q, shift_nx;
  logic [IW-1:0]           idx_q;
  logic [WORD_WIDTH-1:0]   data_q;
  logic                    valid_q, last_q;
  logic                    ovf_q, drained_q;
  logic [15:0]             drop_q;
  logic                    full, pop, push_req, push_ok, drop;

  // MSB of each pointer is the lap bit that separates full from empty.
  assign full = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign fifo_count = wr_q - rd_q;
  assign wr_d = wr_q + 1'b1;
  assign rd_d = rd_q + 1'b1;

  assign pop      = (state_q == IDLE) && (fifo_count != '0);
  assign push_req = trace_ready_i && trace_capture_enable_i && !lock_i;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  assign head     = mem_q[rd_q[AW-1:0]];
  assign shift_nx = shift_q >> WORD_WIDTH;

`ifdef TRACE_DRAIN_TIMESTAMP_EN
  logic [31:0] ts_q [FIFO_DEPTH];
  logic [31:0] head_ts;
  assign head_ts = ts_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) ts_q[wr_q[AW-1:0]] <= counter_i;
  end
`else
  logic unused_counter;
  assign unused_counter = ^counter_i;
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= trace_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      drained_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_d;
      if (pop)     rd_q <= rd_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      if (lock_i && fifo_count == '0 && state_q == IDLE)
        drained_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (pop) begin
          shift_q <= head;
          idx_q   <= '0;
          valid_q <= 1'b1;
`ifdef TRACE_DRAIN_TIMESTAMP_EN
          state_q <= HDR;
          data_q  <= WORD_WIDTH'(head_ts);
          last_q  <= 1'b0;
`else
          state_q <= SEND;
          data_q  <= head[WORD_WIDTH-1:0];
          last_q  <= (WORDS == 1);
`endif
        end
`ifdef TRACE_DRAIN_TIMESTAMP_EN
        HDR: if (out_ready) begin
          state_q <= SEND;
          data_q  <= shift_q[WORD_WIDTH-1:0];
          last_q  <= (WORDS == 1);
        end
`endif
        SEND: if (out_ready) begin
          if (last_q) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            shift_q <= shift_nx;
            data_q  <= shift_nx[WORD_WIDTH-1:0];
            idx_q   <= idx_q + 1'b1;
            last_q  <= (int'(idx_q) == WORDS - 2);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign drained    = drained_q;

endmodule

// File: tb/tb_trace_drain.sv
// Directed bench for trace_drain: framing, backpressure, overflow, lock, reset.
// Follows TRACE_DRAIN_TIMESTAMP_EN when defined.
module tb_trace_drain;

`ifdef TRACE_DRAIN_TIMESTAMP_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] trace_data;
  logic         trace_ready;
  logic         cap_en;
  logic         lock;
  logic [31:0]  counter;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic [3:0]   fifo_count;
  logic         overflow;
  logic [15:0]  drop_count;
  logic         drained;

  int vecs = 0;
  int errs = 0;

  logic [127:0] rec1;

  trace_drain dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .trace_data_i           (trace_data),
    .trace_ready_i          (trace_ready),
    .trace_capture_enable_i (cap_en),
    .lock_i                 (lock),
    .counter_i              (counter),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_last               (out_last),
    .out_ready              (out_ready),
    .fifo_count             (fifo_count),
    .overflow               (overflow),
    .drop_count             (drop_count),
    .drained                (drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] r);
    trace_data  = r;
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rec(input int r);
    return {8'(r), 24'd3, 8'(r), 24'd2, 8'(r), 24'd1, 8'(r), 24'd0};
  endfunction

  function automatic logic [31:0] first_word(input int r);
`ifdef TRACE_DRAIN_TIMESTAMP_EN
    return 32'd100 + 32'(r - r);
`else
    return {8'(r), 24'd0};
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    int w;
    int c;
    rec1        = 128'h44444444_33333333_22222222_11111111;
    rst_n       = 1'b0;
    trace_data  = '0;
    trace_ready = 1'b0;
    cap_en      = 1'b1;
    lock        = 1'b0;
    counter     = 32'd100;
    out_ready   = 1'b0;
    step();
    step();

    // reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_drained", drained, 0);
    rst_n = 1'b1;

    // 1: single record, latency and word order
    out_ready = 1'b1;
    push(rec1);
    chk("t1_count_n1", fifo_count, 1);
    chk("t1_valid_n1", out_valid, 0);
    step();
    chk("t1_valid_n2", out_valid, 1);
    chk("t1_count_n2", fifo_count, 0);
`ifdef TRACE_DRAIN_TIMESTAMP_EN
    chk("t1_hdr", out_data, 32'h64);
    chk("t1_hdr_last", out_last, 0);
    step();
`endif
    for (int k = 0; k < 4; k++) begin
      chk("t1_word", out_data, rec1[k*32 +: 32]);
      chk("t1_last", out_last, (k == 3) ? 1 : 0);
      step();
    end
    chk("t1_done", out_valid, 0);

    // 2: backpressure holding word 1
    push(rec1);
    step();
`ifdef TRACE_DRAIN_TIMESTAMP_EN
    chk("t2_hdr", out_data, 32'h64);
    step();
`endif
    chk("t2_w0", out_data, 32'h11111111);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_data", out_data, 32'h22222222);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_last", out_last, 0);
      step();
    end
    out_ready = 1'b1;
    chk("t2_w1", out_data, 32'h22222222);
    step();
    chk("t2_w2", out_data, 32'h33333333);
    step();
    chk("t2_w3", out_data, 32'h44444444);
    chk("t2_w3_last", out_last, 1);
    step();
    chk("t2_done", out_valid, 0);

    // 3: overflow with 11 pushes against a stalled stream
    do_reset();
    out_ready = 1'b0;
    for (int r = 1; r <= 11; r++) begin
      trace_data  = rec(r);
      trace_ready = 1'b1;
      step();
    end
    trace_ready = 1'b0;
    chk("t3_count", fifo_count, 8);
    chk("t3_drop", drop_count, 2);
    chk("t3_ovf", overflow, 1);
    out_ready = 1'b1;
    frames = 0;
    w = 0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid) begin
        if (w == 0) chk("t3_first_word", out_data, first_word(frames + 1));
        if (out_last) begin
          frames++;
          w = 0;
        end else begin
          w++;
        end
      end
      step();
    end
    chk("t3_frames", frames, 9);
    chk("t3_empty", fifo_count, 0);

    // 4: push into a full FIFO while the serialiser pops
    do_reset();
    out_ready = 1'b0;
    for (int r = 1; r <= 9; r++) push(rec(r));
    chk("t4_full", fifo_count, 8);
    chk("t4_drop0", drop_count, 0);
    out_ready = 1'b1;
    for (int k = 0; k < FRAME; k++) step();
    chk("t4_idle", out_valid, 0);
    chk("t4_full_idle", fifo_count, 8);
    out_ready = 1'b0;
    push(rec(10));
    chk("t4_count", fifo_count, 8);
    chk("t4_drop", drop_count, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_valid", out_valid, 1);

    // 5: lock drain
    do_reset();
    out_ready = 1'b0;
    for (int r = 1; r <= 3; r++) push(rec(r));
    chk("t5_count", fifo_count, 2);
    lock        = 1'b1;
    trace_data  = rec(4);
    trace_ready = 1'b1;
    step();
    step();
    trace_ready = 1'b0;
    chk("t5_drop", drop_count, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_count_lock", fifo_count, 2);
    chk("t5_not_drained", drained, 0);
    out_ready = 1'b1;
    frames = 0;
    c = 0;
    while (!drained && c < 60) begin
      if (out_valid && out_last) frames++;
      step();
      c++;
    end
    chk("t5_drained", drained, 1);
    chk("t5_frames_at_drain", frames, 3);
    lock = 1'b0;
    step();
    step();
    step();
    chk("t5_sticky", drained, 1);
    chk("t5_empty", fifo_count, 0);

    // 6: reset mid-frame
    do_reset();
    chk("t6_drained_clr", drained, 0);
    out_ready = 1'b1;
    push(rec1);
    step();
`ifdef TRACE_DRAIN_TIMESTAMP_EN
    step();
`endif
    step();
    step();
    chk("t6_mid", out_data, 32'h33333333);
    rst_n = 1'b0;
    step();
    chk("t6_valid", out_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_drop", drop_count, 0);
    rst_n = 1'b1;
    push(rec1);
    step();
    chk("t6_new_valid", out_valid, 1);
`ifdef TRACE_DRAIN_TIMESTAMP_EN
    chk("t6_new_first", out_data, 32'h00000064);
`else
    chk("t6_new_first", out_data, 32'h11111111);
`endif
    chk("t6_new_last", out_last, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/trace_drain.md
Name: trace_drain

Overview:
Consumer end of the tracer's record output. Captures each completed trace record on the trace-ready strobe and buffers it in a FIFO. Serialises each record into fixed-width words on a valid/ready stream with end-of-record framing for off-chip transport or a memory writer. Tracks drops on overflow and reports when the stream has fully drained after the tracer locks.

Parameters:
RECORD_WIDTH, 128, width of one packed trace record; must be a multiple of WORD_WIDTH
WORD_WIDTH, 32, stream word width
FIFO_DEPTH, 8, record FIFO entries; power of two, >=2

Ports:
clk  input  1  clock
rst_n  input  1  synchronous, active-low reset
trace_data_i  input  RECORD_WIDTH  packed trace record
trace_ready_i  input  1  one-cycle strobe: trace_data_i valid this cycle
trace_capture_enable_i  input  1  record is accepted only when high
lock_i  input  1  tracer locked; no further records accepted
counter_i  input  32  tracer cycle counter (used only with the optional feature)
out_data  output  WORD_WIDTH  stream data
out_valid  output  1  stream valid
out_last  output  1  final word of a record
out_ready  input  1  downstream ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  records held in FIFO, excluding the serialiser
overflow  output  1  sticky: at least one record dropped
drop_count  output  16  dropped records, saturating at 0xFFFF
drained  output  1  lock seen and all accepted records sent

Behaviour:
- Reset: synchronous; every output 0 and FIFO empty. Serialiser returns to IDLE. Any in-flight record is discarded and out_valid is low the cycle after reset sampled.
- Push: push_req = trace_ready_i && trace_capture_enable_i && !lock_i.
- Push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- A push that is not accepted increments drop_count (saturating) and sets overflow. A push while lock_i is high is ignored and is not counted as a drop.
- WORDS = RECORD_WIDTH/WORD_WIDTH.
- FSM IDLE: if fifo_count>0, pop the head into the shift register, set word index=0, go to SEND.
- FSM SEND: out_valid=1 and out_data = the current word.
  - Words go least-significant first: word k = bits [k*WORD_WIDTH +: WORD_WIDTH].
  - out_last=1 when index==WORDS-1.
  - On out_valid&&out_ready: index++. On the last word, go to IDLE.
- Latency: push at cycle N gives fifo_count=1 at N+1, pop at N+1, out_valid=1 at N+2. Back-to-back records have one idle bubble between them.
- Stream rule: while out_valid && !out_ready, out_data and out_last stay stable and out_valid stays high.
- Total capacity is FIFO_DEPTH+1 records: FIFO plus shift register.
- drained: set when lock_i==1, fifo_count==0 and FSM==IDLE (with the optional feature: HDR/SEND are also idle). Stays set until reset, even if lock_i later deasserts. Records arriving after lock are ignored.
- fifo_count wraps correctly through pointer wrap-around. Pointers use a separate full/empty bit, not count comparison alone.

Optional Feature:
TRACE_DRAIN_TIMESTAMP_EN
- Defined:
  - counter_i is captured into the FIFO entry alongside the record at push.
  - The FSM gains state HDR between IDLE and SEND. HDR emits counter_i's captured value, zero-extended or truncated to WORD_WIDTH, as word 0 with out_last=0.
  - Each frame is WORDS+1 words; latency to the first word is unchanged.
- Undefined: counter_i is ignored, there is no HDR state, and frames are WORDS words.

Test Plan:
1. Single record 0x44444444_33333333_22222222_11111111 pushed at N, out_ready=1 -> out_valid from N+2. Words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; out_last only on the 4th.
2. Backpressure: out_ready=0 for 5 cycles mid-record after word 1 -> out_data holds 0x22222222 with out_valid=1 throughout. Resumes with no loss or duplicate.
3. Overflow: out_ready=0, push 11 records -> 9 accepted, fifo_count=8, drop_count=2, overflow=1. Releasing out_ready then yields exactly 9 frames.
4. Full with simultaneous pop: FIFO full and serialiser in IDLE popping while a push arrives -> push accepted, drop_count unchanged, fifo_count stays 8.
5. Lock drain: 3 records queued, lock_i=1, further strobes -> strobes ignored with no drops. drained=1 only after the 3rd record's out_last handshake and stays 1 after lock_i falls.
6. Reset mid-frame after word 2 -> out_valid=0, fifo_count=0, drop_count=0 the next cycle. A new record afterwards starts at word 0 (with the optional feature: first word = timestamp 0x00000064 for counter_i=100 at push).
